// File: rtl/nios_gpio_strobe.sv
// Avalon-MM GPIO with edge capture, level irq and a programmable one-shot strobe pulse.
// Latency: zero-wait-state reads; writes take effect on the next clk edge; in_port edges captured 3 edges later.
// Backpressure: none; the slave always accepts and answers in the same cycle.
module nios_gpio_strobe #(
  parameter int          DATA_WIDTH  = 16,
  parameter logic [31:0] RESET_VALUE = 32'd0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          PULSE_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_strobe,
  output logic                  irq
);

  localparam logic [DATA_WIDTH-1:0] DATA_RST = RESET_VALUE[DATA_WIDTH-1:0];

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [PULSE_W-1:0]    wr_len;
  logic                  unused_wd;

  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_cap;
  logic [DATA_WIDTH-1:0] cap_clr;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] sync1;
  logic [DATA_WIDTH-1:0] sync2;
  logic [DATA_WIDTH-1:0] prev;
  logic [PULSE_W-1:0]    pulse_len;

  state_t                state, state_next;
  logic [PULSE_W-1:0]    count, count_next;
  logic                  strobe_wr;

  assign wr_en     = chipselect & ~write_n;
  assign wr_dat    = writedata[DATA_WIDTH-1:0];
  assign wr_len    = writedata[PULSE_W-1:0];
  // Upper writedata bits are ignored when the registers are narrower than the bus.
  assign unused_wd = ^writedata;
  assign strobe_wr = wr_en && (address == 3'd7);
  assign cap_clr   = (wr_en && (address == 3'd3)) ? wr_dat : '0;

  // DATA register: direct load, bitwise set and bitwise clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= DATA_RST;
    end else if (wr_en) begin
      case (address)
        3'd0:    data_reg <= wr_dat;
        3'd4:    data_reg <= data_reg | wr_dat;
        3'd5:    data_reg <= data_reg & ~wr_dat;
        default: data_reg <= data_reg;
      endcase
    end
  end

  // Plain R/W control registers: interrupt mask and pulse length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask  <= '0;
      pulse_len <= '0;
    end else if (wr_en) begin
      if (address == 3'd2) irq_mask  <= wr_dat;
      if (address == 3'd6) pulse_len <= wr_len;
    end
  end

  // Two-flop synchroniser followed by the history register used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Per-bit edge detection in the direction chosen by EDGE_TYPE.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = sync2 & ~prev;
      1:       edge_det = ~sync2 & prev;
      default: edge_det = sync2 ^ prev;
    endcase
  end

  // Sticky capture; a fresh edge wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= '0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
    end
  end

  // Pulse FSM state and down-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Pulse FSM next state: load on an accepted strobe, count down while active, drop out after the last cycle.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (strobe_wr && (pulse_len != '0)) begin
          state_next = ACTIVE;
          count_next = pulse_len;
        end
      end
      ACTIVE: begin
        count_next = count - PULSE_W'(1);
        if (count == PULSE_W'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_strobe = (state == ACTIVE);
  assign out_port   = data_reg;
  assign irq        = |(edge_cap & irq_mask);

  // Combinational read mux, zero-extended; write-only addresses read as zero.
  always_comb begin
    readdata = 32'd0;
    case (address)
      3'd0:    readdata = 32'(data_reg);
      3'd1:    readdata = 32'(sync2);
      3'd2:    readdata = 32'(irq_mask);
      3'd3:    readdata = 32'(edge_cap);
      3'd6:    readdata = 32'(pulse_len);
      3'd7:    readdata = {31'd0, out_strobe};
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_nios_gpio_strobe.sv
// Directed bench for nios_gpio_strobe with a cycle-level reference model and literal spot checks.
// Inputs change 1 time unit after each rising edge; outputs are compared on falling edges.
// No backpressure on this slave; every access completes in one cycle.
module tb_nios_gpio_strobe;

  localparam int          DW   = 16;
  localparam logic [31:0] RSTV = 32'h0000A5C3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] in_port;
  logic [DW-1:0] out_port;
  logic          out_strobe;
  logic          irq;

  int tests = 0;
  int fails = 0;

  nios_gpio_strobe #(
    .DATA_WIDTH (DW),
    .RESET_VALUE(RSTV),
    .EDGE_TYPE  (0),
    .PULSE_W    (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .out_strobe(out_strobe),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, the last three in_port samples and cycles of pulse left.
  logic [DW-1:0] m_data, m_mask, m_cap, m_len;
  logic [DW-1:0] m_samp [0:2];   // [0] newest sample, [1] value seen by IN, [2] one cycle older
  int            m_rem;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data = RSTV[DW-1:0];
      m_mask = '0;
      m_cap  = '0;
      m_len  = '0;
      m_rem  = 0;
      for (int i = 0; i < 3; i++) m_samp[i] = '0;
    end else begin
      logic          wr;
      logic [DW-1:0] wd, clr, rise;
      wr   = chipselect && !write_n;
      wd   = writedata[DW-1:0];
      clr  = (wr && address == 3'd3) ? wd : '0;
      rise = m_samp[1] & ~m_samp[2];
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (wr && address == 3'd7 && m_len != 0) m_rem = int'(m_len);
      if (wr) begin
        case (address)
          3'd0: m_data = wd;
          3'd2: m_mask = wd;
          3'd4: m_data = m_data | wd;
          3'd5: m_data = m_data & ~wd;
          3'd6: m_len  = wd;
          default: ;
        endcase
      end
      m_cap = (m_cap & ~clr) | rise;
      m_samp[2] = m_samp[1];
      m_samp[1] = m_samp[0];
      m_samp[0] = in_port;
    end
  end

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return 32'(m_data);
      3'd1:    return 32'(m_samp[1]);
      3'd2:    return 32'(m_mask);
      3'd3:    return 32'(m_cap);
      3'd6:    return 32'(m_len);
      3'd7:    return (m_rem > 0) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("model out_port",   32'(out_port), 32'(m_data));
      chk("model out_strobe", 32'(out_strobe), (m_rem > 0) ? 32'd1 : 32'd0);
      chk("model irq",        32'(irq), 32'(|(m_cap & m_mask)));
      chk("model readdata",   readdata, m_read(address));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  logic [DW-1:0] pat [0:5];
  int hi_cnt;

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; in_port = '0;
    pat[0] = 16'h0003; pat[1] = 16'h8001; pat[2] = 16'h8000;
    pat[3] = 16'h00F0; pat[4] = 16'h0000; pat[5] = 16'hFFFF;
    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("reset out_port", 32'(out_port), RSTV);
    chk("reset out_strobe", 32'(out_strobe), 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    rd_chk("reset edge_cap", 3'd3, 32'd0);

    // DATA load / set / clear
    bus_write(3'd0, 32'h1234); chk("data load", 32'(out_port), 32'h1234);
    bus_write(3'd4, 32'h00F0); chk("data set", 32'(out_port), 32'h12F4);
    bus_write(3'd5, 32'h0204); chk("data clr", 32'(out_port), 32'h10F0);
    rd_chk("read data", 3'd0, 32'h000010F0);
    rd_chk("read outset", 3'd4, 32'd0);
    rd_chk("read outclr", 3'd5, 32'd0);

    // Rising edge capture timing and W1C
    bus_write(3'd2, 32'h0001);
    in_port[0] = 1'b1;
    idle(2); chk("edge not yet", 32'(irq), 32'd0);
    idle(1); chk("edge irq", 32'(irq), 32'd1);
    rd_chk("edge cap", 3'd3, 32'd1);
    rd_chk("in reads sync", 3'd1, 32'd1);
    bus_write(3'd3, 32'h1); chk("w1c irq", 32'(irq), 32'd0);

    // W1C colliding with a fresh edge detection
    in_port[0] = 1'b0;
    idle(4); chk("falling ignored", 32'(irq), 32'd0);
    in_port[0] = 1'b1;
    idle(2);
    bus_write(3'd3, 32'h1); chk("w1c collide irq", 32'(irq), 32'd1);
    rd_chk("w1c collide cap", 3'd3, 32'd1);
    bus_write(3'd3, 32'h1); chk("w1c after", 32'(irq), 32'd0);

    // Pattern sweep over all bits, checked by the model
    bus_write(3'd2, 32'hFFFF);
    for (int p = 0; p < 6; p++) begin
      in_port = pat[p];
      for (int c = 0; c < 4; c++) begin
        address = (c % 2 == 0) ? 3'd1 : 3'd3;
        idle(1);
      end
    end
    bus_write(3'd3, 32'hFFFF);
    chk("sweep clear irq", 32'(irq), 32'd0);

    // Pulse of 5 with ignored re-strobe and length change while active
    bus_write(3'd6, 32'd5);
    bus_write(3'd7, 32'd1);
    hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_strobe) hi_cnt++;
      if (i == 0) rd_chk("busy during", 3'd7, 32'd1);
      if (i == 1) bus_write(3'd7, 32'd1);
      else if (i == 2) bus_write(3'd6, 32'd9);
      else idle(1);
    end
    chk("pulse length", 32'(hi_cnt), 32'd5);
    rd_chk("busy after", 3'd7, 32'd0);

    // Zero length never pulses
    bus_write(3'd6, 32'd0);
    bus_write(3'd7, 32'd1);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_strobe) hi_cnt++;
      idle(1);
    end
    chk("zero len pulse", 32'(hi_cnt), 32'd0);
    rd_chk("zero len busy", 3'd7, 32'd0);

    // Asynchronous reset mid-pulse
    bus_write(3'd0, 32'hFFFF);
    bus_write(3'd6, 32'd5);
    bus_write(3'd7, 32'd1);
    idle(1);
    chk("pulse running", 32'(out_strobe), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst strobe", 32'(out_strobe), 32'd0);
    chk("async rst out_port", 32'(out_port), RSTV);
    chk("async rst irq", 32'(irq), 32'd0);
    @(posedge clk); #3 reset_n = 1'b1;
    idle(1);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_strobe) hi_cnt++;
      idle(1);
    end
    chk("no resume", 32'(hi_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nios_gpio_strobe.md
NIOS_GPIO_STROBE -- requirements
Module: nios_gpio_strobe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the width of out_port, in_port and every data register (legal range 1..32).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, giving the DATA register value after reset.
REQ-003 The block SHALL have parameter EDGE_TYPE, default 0, selecting edge capture (0 rising, 1 falling, 2 any).
REQ-004 The block SHALL have parameter PULSE_W, default 16, giving the width of the PULSE_LEN register and the pulse counter.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-006 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port address, input, 3 bits, Avalon-MM register select.
REQ-008 The block SHALL have port chipselect, input, 1 bit, Avalon-MM slave select.
REQ-009 The block SHALL have port write_n, input, 1 bit, active-low write strobe.
REQ-010 The block SHALL have port writedata, input, 32 bits, write data.
REQ-011 The block SHALL have port readdata, output, 32 bits, read data.
REQ-012 The block SHALL have port in_port, input, DATA_WIDTH bits, asynchronous external inputs.
REQ-013 The block SHALL have port out_port, output, DATA_WIDTH bits, the DATA register.
REQ-014 The block SHALL have port out_strobe, output, 1 bit, the timed pulse.
REQ-015 The block SHALL have port irq, output, 1 bit, the level interrupt.

Function
REQ-016 A write SHALL occur on a rising clk edge with chipselect=1 and write_n=0; only writedata[DATA_WIDTH-1:0] (or [PULSE_W-1:0] for PULSE_LEN) is used.
REQ-017 Register map: 0 DATA (R/W), 1 IN (RO, synchronised in_port), 2 IRQ_MASK (R/W), 3 EDGE_CAP (R, write-1-to-clear), 4 OUTSET (WO, DATA |= wd), 5 OUTCLR (WO, DATA &= ~wd), 6 PULSE_LEN (R/W), 7 STROBE (write starts pulse; read returns busy in bit 0).
REQ-018 readdata SHALL be combinational from address, zero wait states, zero-extended to 32 bits; write-only addresses 4 and 5 SHALL read 0.
REQ-019 in_port SHALL pass through a two-flop synchroniser (sync2) and a history register (prev); IN reads sync2.
REQ-020 An edge SHALL be detected per bit when sync2 and prev differ in the direction given by EDGE_TYPE; it sets EDGE_CAP on that clk edge, i.e. the third rising clk edge after in_port changes (setup met).
REQ-021 When an edge detection and a write-1-to-clear hit the same EDGE_CAP bit in the same cycle, the bit SHALL remain set.
REQ-022 irq SHALL equal OR-reduction of (EDGE_CAP & IRQ_MASK), combinationally from registers.
REQ-023 Pulse state machine IDLE/ACTIVE: in IDLE, a STROBE write with PULSE_LEN nonzero loads counter=PULSE_LEN and enters ACTIVE; with PULSE_LEN=0 it stays IDLE.
REQ-024 In ACTIVE, out_strobe=1, the counter decrements each cycle, and the state returns to IDLE on the edge where counter=1, giving exactly PULSE_LEN cycles of out_strobe high, starting the cycle after the write.
REQ-025 STROBE writes during ACTIVE SHALL be ignored; PULSE_LEN writes during ACTIVE SHALL not affect the running pulse.
REQ-026 out_strobe SHALL be registered (state-decoded from a flop), glitch-free.

Reset
REQ-027 On reset_n=0, asynchronously: DATA=RESET_VALUE, IRQ_MASK=0, EDGE_CAP=0, PULSE_LEN=0, counter=0, state IDLE, sync/prev=0; hence out_port=RESET_VALUE, out_strobe=0, irq=0.
REQ-028 Reset asserted during ACTIVE SHALL terminate the pulse immediately; after release no pulse resumes.

Verification
REQ-029 Write 0x1234 to 0, 0x00F0 to 4, 0x0204 to 5 -> out_port 0x1234, 0x12F4, 0x10F0; read 0 returns 0x000010F0.
REQ-030 EDGE_TYPE=0, IRQ_MASK=0x0001, in_port[0] 0->1 -> EDGE_CAP[0]=1 on 3rd clk edge, irq=1; write 0x1 to 3 -> irq=0.
REQ-031 W1C to EDGE_CAP[0] in the same cycle a new rising edge is detected -> EDGE_CAP[0] stays 1, irq stays 1.
REQ-032 PULSE_LEN=5, write STROBE -> out_strobe high exactly 5 cycles from next cycle; second STROBE write at cycle 2 ignored; read 7 returns 1 during, 0 after.
REQ-033 PULSE_LEN=0, write STROBE -> out_strobe never asserts; read 7 returns 0.
REQ-034 Assert reset_n=0 mid-pulse with DATA=0xFFFF -> out_strobe=0 and out_port=RESET_VALUE without waiting for clk.
